// File: rtl/wb_qspi_flash_prog_if.sv
// Wishbone slave bundle for the flash program/erase engine.
// The bench drives the master side; the engine sits on the slave side.
interface wb_qspi_flash_prog_if #(
    parameter int AW = 4
);
    logic [AW-1:0] wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_we_i;
    logic          wb_stb_i;
    logic          wb_cyc_i;
    logic [3:0]    wb_sel_i;
    logic          wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_qspi_flash_prog.sv
// SPI flash program/erase sequencer (WREN, erase/program, status polling) with payload FIFO.
// Define WB_QSPI_FLASH_PROG_QUAD_EN for quad-input page program (0x32, 4-lane data).
module wb_qspi_flash_prog #(
    parameter int AW         = 4,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_reset_i,
    wb_qspi_flash_prog_if.slave  wb,
    output logic                 busy_o,
    output logic                 spi_clk,
    output logic                 spi_sel,
    output logic [3:0]           spi_d_out,
    input  logic [3:0]           spi_d_in,
    output logic [3:0]           spi_d_dir
);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WREN = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_OPC  = 3'd3;
    localparam logic [2:0] S_ADDR = 3'd4;
    localparam logic [2:0] S_DATA = 3'd5;
    localparam logic [2:0] S_RDSR = 3'd6;

`ifdef WB_QSPI_FLASH_PROG_QUAD_EN
    localparam logic       QUAD  = 1'b1;
    localparam logic [7:0] PP_OP = 8'h32;
`else
    localparam logic       QUAD  = 1'b0;
    localparam logic [7:0] PP_OP = 8'h02;
`endif

    logic          ack;
    logic [31:0]   dat_o;
    logic [DW-1:0] rd_word;
    logic [23:0]   addr;
    logic          ovf;
    logic          cmd_go;
    logic [1:0]    cmd_op;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   level;
    logic [6:0]    lvl7;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;

    logic [2:0]    st;
    logic [1:0]    op_q;
    logic          busy, sck, sel, end_pend, rd_phase, quad_q, gap_to_rdsr;
    logic [3:0]    d_out, dir, bit_cnt;
    logic [1:0]    byte_idx, gap_cnt;
    logic [7:0]    tx_sr, stat_byte, rx_byte;
    logic [6:0]    rx_sr;
    logic [23:0]   word_q;

    logic acc, wr_acc, cmd_wr, addr_wr, data_wr, framed, rise, byte_done;
    logic unused_bits;

    assign acc     = wb.wb_stb_i & wb.wb_cyc_i & ~ack;
    assign wr_acc  = acc & wb.wb_we_i;
    assign cmd_wr  = wr_acc && (wb.wb_adr_i[1:0] == 2'd0);
    assign addr_wr = wr_acc && (wb.wb_adr_i[1:0] == 2'd1);
    assign data_wr = wr_acc && (wb.wb_adr_i[1:0] == 2'd2);

    assign fifo_full  = (level == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign lvl7       = 7'(level);

    // A byte completes on the rising SCK edge that shifts in its last bit.
    assign framed    = !sel && (st != S_IDLE) && (st != S_GAP) && !end_pend;
    assign rise      = framed && !sck;
    assign byte_done = rise && (bit_cnt == 4'd1);
    assign rx_byte   = {rx_sr, spi_d_in[1]};
    assign fifo_pop  = byte_done && !fifo_empty &&
                       (((st == S_ADDR) && (byte_idx == 2'd2) && (op_q == 2'd2)) ||
                        ((st == S_DATA) && (byte_idx == 2'd3)));
    assign fifo_push = data_wr && (!fifo_full || fifo_pop);

    assign wb.wb_ack_o = ack;
    assign wb.wb_dat_o = dat_o;
    assign busy_o      = busy;
    assign spi_clk     = sck;
    assign spi_sel     = sel;
    assign spi_d_out   = d_out;
    assign spi_d_dir   = dir;
    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[AW-1:2], spi_d_in[3:2], spi_d_in[0]};

    always_comb begin
        rd_word = '0;
        case (wb.wb_adr_i[1:0])
            2'd1:    rd_word = {8'h00, addr};
            2'd3:    rd_word = {9'h000, lvl7, stat_byte, 4'h0, fifo_empty, fifo_full, ovf, busy};
            default: rd_word = '0;
        endcase
    end

    // Bus side: registers, acknowledge and FIFO bookkeeping
    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_i) begin
            ack    <= 1'b0;
            dat_o  <= '0;
            addr   <= '0;
            ovf    <= 1'b0;
            cmd_go <= 1'b0;
            cmd_op <= 2'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            ack    <= acc;
            dat_o  <= (acc && !wb.wb_we_i) ? rd_word : '0;
            cmd_go <= cmd_wr && !busy && (wb.wb_dat_i[1:0] != 2'd0);
            if (cmd_wr && !busy)
                cmd_op <= wb.wb_dat_i[1:0];
            if (addr_wr)
                addr <= wb.wb_dat_i[23:0];
            if (cmd_wr && !busy)
                ovf <= 1'b0;
            else if (data_wr && !fifo_push)
                ovf <= 1'b1;
            if (fifo_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (fifo_push && !fifo_pop)
                level <= level + 1'b1;
            else if (!fifo_push && fifo_pop)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (fifo_push)
            mem[wr_ptr] <= wb.wb_dat_i;
    end

    // Flash side: frame sequencing and bit engine
    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_i) begin
            st          <= S_IDLE;
            op_q        <= 2'd0;
            busy        <= 1'b0;
            sck         <= 1'b1;
            sel         <= 1'b1;
            d_out       <= 4'h0;
            dir         <= 4'h0;
            stat_byte   <= 8'h00;
            end_pend    <= 1'b0;
            rd_phase    <= 1'b0;
            quad_q      <= 1'b0;
            gap_to_rdsr <= 1'b0;
            bit_cnt     <= 4'd0;
            byte_idx    <= 2'd0;
            gap_cnt     <= 2'd0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (cmd_go) begin
                        busy     <= 1'b1;
                        op_q     <= cmd_op;
                        sel      <= 1'b0;
                        bit_cnt  <= 4'd8;
                        byte_idx <= 2'd0;
                        tx_sr    <= (cmd_op == 2'd3) ? 8'h05 : 8'h06;
                        st       <= (cmd_op == 2'd3) ? S_RDSR : S_WREN;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 2'd0) begin
                        sel      <= 1'b0;
                        bit_cnt  <= 4'd8;
                        byte_idx <= 2'd0;
                        if (gap_to_rdsr) begin
                            tx_sr <= 8'h05;
                            st    <= S_RDSR;
                        end else begin
                            tx_sr <= (op_q == 2'd1) ? 8'h20 : PP_OP;
                            st    <= S_OPC;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end
                default: begin
                    if (end_pend) begin
                        sel      <= 1'b1;
                        end_pend <= 1'b0;
                        d_out    <= 4'h0;
                        dir      <= 4'h0;
                        rd_phase <= 1'b0;
                        quad_q   <= 1'b0;
                        if (st == S_RDSR) begin
                            st   <= S_IDLE;
                            busy <= 1'b0;
                        end else begin
                            st          <= S_GAP;
                            gap_cnt     <= 2'd3;
                            gap_to_rdsr <= (st != S_WREN);
                        end
                    end else if (sck) begin
                        sck <= 1'b0;
                        if (quad_q) begin
                            d_out <= tx_sr[7:4];
                            tx_sr <= {tx_sr[3:0], 4'h0};
                            dir   <= 4'b1111;
                        end else begin
                            d_out <= {3'b000, tx_sr[7]};
                            tx_sr <= {tx_sr[6:0], 1'b0};
                            dir   <= rd_phase ? 4'b0000 : 4'b0001;
                        end
                    end else begin
                        sck   <= 1'b1;
                        rx_sr <= rx_byte[6:0];
                        if (bit_cnt != 4'd1) begin
                            bit_cnt <= bit_cnt - 4'd1;
                        end else begin
                            bit_cnt  <= 4'd8;
                            byte_idx <= byte_idx + 2'd1;
                            case (st)
                                S_WREN: end_pend <= 1'b1;
                                S_OPC: begin
                                    tx_sr    <= addr[23:16];
                                    byte_idx <= 2'd0;
                                    st       <= S_ADDR;
                                end
                                S_ADDR: begin
                                    if (byte_idx == 2'd0)
                                        tx_sr <= addr[15:8];
                                    else if (byte_idx == 2'd1)
                                        tx_sr <= addr[7:0];
                                    else if ((op_q == 2'd2) && !fifo_empty) begin
                                        tx_sr    <= mem[rd_ptr][7:0];
                                        word_q   <= mem[rd_ptr][31:8];
                                        byte_idx <= 2'd0;
                                        quad_q   <= QUAD;
                                        bit_cnt  <= QUAD ? 4'd2 : 4'd8;
                                        st       <= S_DATA;
                                    end else
                                        end_pend <= 1'b1;
                                end
                                S_DATA: begin
                                    bit_cnt <= quad_q ? 4'd2 : 4'd8;
                                    if (byte_idx != 2'd3) begin
                                        tx_sr  <= word_q[7:0];
                                        word_q <= {8'h00, word_q[23:8]};
                                    end else if (!fifo_empty) begin
                                        tx_sr    <= mem[rd_ptr][7:0];
                                        word_q   <= mem[rd_ptr][31:8];
                                        byte_idx <= 2'd0;
                                    end else
                                        end_pend <= 1'b1;
                                end
                                default: begin
                                    // First byte is the 0x05 opcode; every later byte is a status poll.
                                    if (rd_phase) begin
                                        stat_byte <= rx_byte;
                                        if (!rx_byte[0])
                                            end_pend <= 1'b1;
                                    end
                                    rd_phase <= 1'b1;
                                    tx_sr    <= 8'h00;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_qspi_flash_prog.sv
// Directed bench for wb_qspi_flash_prog with a behavioural SPI flash that logs frames.
module tb_wb_qspi_flash_prog;
    logic       wb_clk_i   = 1'b0;
    logic       wb_reset_i = 1'b0;
    logic       busy_o, spi_clk, spi_sel;
    logic [3:0] spi_d_out, spi_d_dir;
    logic [3:0] spi_d_in = 4'h0;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef WB_QSPI_FLASH_PROG_QUAD_EN
    localparam logic [7:0] PP_OP = 8'h32;
`else
    localparam logic [7:0] PP_OP = 8'h02;
`endif

    wb_qspi_flash_prog_if #(.AW(4)) wbi ();

    wb_qspi_flash_prog #(.AW(4), .DW(32), .FIFO_DEPTH(16)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_reset_i(wb_reset_i),
        .wb        (wbi),
        .busy_o    (busy_o),
        .spi_clk   (spi_clk),
        .spi_sel   (spi_sel),
        .spi_d_out (spi_d_out),
        .spi_d_in  (spi_d_in),
        .spi_d_dir (spi_d_dir)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Flash model: everything is observed mid-cycle on the falling wb clock.
    logic [7:0] stat_v [8];
    int         stat_n = 0;
    logic [7:0] log_b [$];
    logic [3:0] nib_q [$];
    int fr_start [$];
    int fr_len   [$];
    int fr_stat  [$];
    int fr_busy  [$];
    int gap_q    [$];
    logic       prev_sel = 1'b1;
    logic       prev_sck = 1'b1;
    logic [7:0] sr = 8'h00;
    logic [7:0] cur = 8'h00;
    int bitc = 0, sbit = 0, sidx = 0, cur_start = 0, gap_m = 100;
    logic rd_mode = 1'b0;

    always @(negedge wb_clk_i) begin
        if (prev_sel && !spi_sel) begin
            cur_start = log_b.size();
            fr_start.push_back(cur_start);
            gap_q.push_back(gap_m);
            bitc = 0; sbit = 0; sidx = 0; rd_mode = 1'b0;
        end else if (!prev_sel && spi_sel) begin
            fr_len.push_back(log_b.size() - cur_start);
            fr_stat.push_back(sidx);
            fr_busy.push_back(int'(busy_o));
            gap_m = 1;
        end else if (spi_sel) begin
            gap_m = gap_m + 1;
        end
        if (!spi_sel && !prev_sck && spi_clk) begin
            if (spi_d_dir == 4'b1111) begin
                sr = {sr[3:0], spi_d_out};
                nib_q.push_back(spi_d_out);
                bitc = bitc + 4;
            end else if (spi_d_dir == 4'b0001) begin
                sr = {sr[6:0], spi_d_out[0]};
                bitc = bitc + 1;
            end
            if (bitc == 8) begin
                log_b.push_back(sr);
                bitc = 0;
                if ((log_b.size() - cur_start == 1) && (sr == 8'h05))
                    rd_mode = 1'b1;
            end
        end else if (!spi_sel && prev_sck && !spi_clk && rd_mode) begin
            if (sbit == 0 && sidx < 8)
                sidx = sidx + 1;
            cur = (sidx <= stat_n) ? stat_v[sidx-1] : 8'h00;
            spi_d_in = {2'b00, cur[7-sbit], 1'b0};
            sbit = (sbit == 7) ? 0 : sbit + 1;
        end
        prev_sel = spi_sel;
        prev_sck = spi_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        int lat = 0;
        @(negedge wb_clk_i);
        wbi.wb_adr_i = {2'b00, a};
        wbi.wb_dat_i = d;
        wbi.wb_we_i  = we;
        wbi.wb_sel_i = 4'hF;
        wbi.wb_stb_i = 1'b1;
        wbi.wb_cyc_i = 1'b1;
        do begin
            @(posedge wb_clk_i); #1;
            lat++;
        end while (!wbi.wb_ack_o && lat < 4);
        chk("wb_ack_latency", 32'(lat), 32'd1);
        q = wbi.wb_dat_o;
        wbi.wb_stb_i = 1'b0;
        wbi.wb_cyc_i = 1'b0;
        wbi.wb_we_i  = 1'b0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic wb_rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(1'b0, a, 32'h0, q);
        chk(tag, q, exp);
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while (busy_o && c < maxc) begin
            @(posedge wb_clk_i); #1;
            c++;
        end
        chk("busy_timeout", 32'(busy_o), 32'd0);
        repeat (3) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk_frame(input string tag, input int f, input logic [7:0] exp[16], input int n);
        chk({tag, "_len"}, 32'(fr_len[f]), 32'(n));
        if (fr_len[f] == n)
            for (int i = 0; i < n; i++)
                chk($sformatf("%s_b%0d", tag, i), 32'(log_b[fr_start[f] + i]), 32'(exp[i]));
    endtask

    logic [7:0] exp_b [16];
    int base, nbase;

    initial begin
        wbi.wb_adr_i = '0; wbi.wb_dat_i = '0; wbi.wb_we_i = 1'b0;
        wbi.wb_stb_i = 1'b0; wbi.wb_cyc_i = 1'b0; wbi.wb_sel_i = 4'h0;
        for (int i = 0; i < 8; i++) stat_v[i] = 8'h00;

        // Power-up reset
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_sel", 32'(spi_sel), 32'd1);
        chk("rst_sck", 32'(spi_clk), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ack", 32'(wbi.wb_ack_o), 32'd0);
        chk("rst_dat", wbi.wb_dat_o, 32'h0);
        chk("rst_dout", 32'(spi_d_out), 32'd0);
        chk("rst_dir", 32'(spi_d_dir), 32'd0);
        @(negedge wb_clk_i) wb_reset_i = 1'b1;
        wb_rd_chk("rst_status", 2'd3, 32'h0000_0008);
        wb_rd_chk("rst_addr", 2'd1, 32'h0);

        // Sector erase with three polls
        wb_wr(2'd1, 32'hFF01_2000);
        wb_rd_chk("addr_rb", 2'd1, 32'h0001_2000);
        stat_v[0] = 8'h03; stat_v[1] = 8'h03; stat_v[2] = 8'h00; stat_n = 3;
        base = fr_len.size();
        @(negedge wb_clk_i);
        wbi.wb_adr_i = 4'd0; wbi.wb_dat_i = 32'd1; wbi.wb_we_i = 1'b1;
        wbi.wb_stb_i = 1'b1; wbi.wb_cyc_i = 1'b1;
        @(posedge wb_clk_i); #1;
        chk("erase_ack", 32'(wbi.wb_ack_o), 32'd1);
        chk("erase_busy_lag", 32'(busy_o), 32'd0);
        wbi.wb_stb_i = 1'b0; wbi.wb_cyc_i = 1'b0; wbi.wb_we_i = 1'b0;
        @(posedge wb_clk_i); #1;
        chk("erase_busy_rise", 32'(busy_o), 32'd1);
        wait_idle(2000);
        chk("erase_nframes", 32'(fr_len.size() - base), 32'd3);
        exp_b[0] = 8'h06;
        chk_frame("erase_wren", base, exp_b, 1);
        exp_b[0] = 8'h20; exp_b[1] = 8'h01; exp_b[2] = 8'h20; exp_b[3] = 8'h00;
        chk_frame("erase_se", base + 1, exp_b, 4);
        exp_b[0] = 8'h05;
        chk_frame("erase_rdsr", base + 2, exp_b, 1);
        chk("erase_polls", 32'(fr_stat[base+2]), 32'd3);
        chk("erase_gap1", 32'(gap_q[base+1]), 32'd4);
        chk("erase_gap2", 32'(gap_q[base+2]), 32'd4);
        chk("erase_busy_mid", 32'(fr_busy[base]), 32'd1);
        chk("erase_busy_end", 32'(fr_busy[base+2]), 32'd0);
        wb_rd_chk("erase_status", 2'd3, 32'h0000_0008);

        // Status read only
        stat_v[0] = 8'h81; stat_v[1] = 8'h02; stat_n = 2;
        base = fr_len.size();
        wb_wr(2'd0, 32'd3);
        wait_idle(2000);
        chk("rdsr_nframes", 32'(fr_len.size() - base), 32'd1);
        exp_b[0] = 8'h05;
        chk_frame("rdsr_frame", base, exp_b, 1);
        chk("rdsr_polls", 32'(fr_stat[base]), 32'd2);
        wb_rd_chk("rdsr_status", 2'd3, 32'h0000_0208);

        // Page program, two words
        wb_wr(2'd2, 32'h4433_2211);
        wb_wr(2'd2, 32'h8877_6655);
        wb_rd_chk("pp_level", 2'd3, 32'h0002_0200);
        wb_wr(2'd1, 32'h0000_0100);
        stat_v[0] = 8'h00; stat_n = 1;
        base = fr_len.size();
        nbase = nib_q.size();
        wb_wr(2'd0, 32'd2);
        wait_idle(3000);
        chk("pp_nframes", 32'(fr_len.size() - base), 32'd3);
        exp_b[0] = PP_OP; exp_b[1] = 8'h00; exp_b[2] = 8'h01; exp_b[3] = 8'h00;
        for (int i = 0; i < 8; i++) exp_b[4+i] = 8'(8'h11 * (i + 1));
        chk_frame("pp_frame", base + 1, exp_b, 12);
        wb_rd_chk("pp_status", 2'd3, 32'h0000_0008);
`ifndef WB_QSPI_FLASH_PROG_QUAD_EN
        chk("pp_single_lane", 32'(nib_q.size() - nbase), 32'd0);
`endif

        // Overflow: 17 pushes into 16 entries
        for (int k = 0; k < 17; k++) wb_wr(2'd2, 32'(k) * 32'h0101_0101);
        wb_rd_chk("ovf_status", 2'd3, 32'h0010_0006);
        stat_v[0] = 8'h00; stat_n = 1;
        wb_wr(2'd0, 32'd3);
        wait_idle(2000);
        wb_rd_chk("ovf_cleared", 2'd3, 32'h0010_0004);

        // Drain with a CMD issued mid-program
        stat_v[0] = 8'h01; stat_v[1] = 8'h40; stat_n = 2;
        base = fr_len.size();
        wb_wr(2'd0, 32'd2);
        repeat (200) @(posedge wb_clk_i);
        #1;
        chk("guard_busy", 32'(busy_o), 32'd1);
        wb_wr(2'd0, 32'd1);
        wait_idle(5000);
        chk("guard_nframes", 32'(fr_len.size() - base), 32'd3);
        chk("drain_len", 32'(fr_len[base+1]), 32'd68);
        chk("drain_w0", 32'(log_b[fr_start[base+1] + 4]), 32'h00);
        chk("drain_w5", 32'(log_b[fr_start[base+1] + 24]), 32'h05);
        chk("drain_last", 32'(log_b[fr_start[base+1] + 67]), 32'h0F);
        wb_rd_chk("drain_status", 2'd3, 32'h0000_4008);

`ifdef WB_QSPI_FLASH_PROG_QUAD_EN
        // Quad data lanes
        wb_wr(2'd2, 32'hDDCC_BBAA);
        wb_wr(2'd1, 32'h0);
        stat_v[0] = 8'h00; stat_n = 1;
        base = fr_len.size();
        nbase = nib_q.size();
        wb_wr(2'd0, 32'd2);
        wait_idle(3000);
        exp_b[0] = 8'h32; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
        exp_b[4] = 8'hAA; exp_b[5] = 8'hBB; exp_b[6] = 8'hCC; exp_b[7] = 8'hDD;
        chk_frame("quad_frame", base + 1, exp_b, 8);
        chk("quad_nibbles", 32'(nib_q.size() - nbase), 32'd8);
        if (nib_q.size() - nbase == 8)
            for (int i = 0; i < 8; i++)
                chk($sformatf("quad_nib%0d", i), 32'(nib_q[nbase + i]), 32'(4'hA + i / 2));
`endif

        // Reset in the middle of a program sequence
        wb_wr(2'd2, 32'h1234_5678);
        wb_wr(2'd2, 32'h9ABC_DEF0);
        stat_v[0] = 8'h00; stat_n = 1;
        wb_wr(2'd0, 32'd2);
        repeat (30) @(posedge wb_clk_i);
        #1;
        chk("midrst_in_frame", 32'(spi_sel), 32'd0);
        @(negedge wb_clk_i) wb_reset_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("midrst_sel", 32'(spi_sel), 32'd1);
        chk("midrst_sck", 32'(spi_clk), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_dir", 32'(spi_d_dir), 32'd0);
        @(negedge wb_clk_i) wb_reset_i = 1'b1;
        wb_rd_chk("midrst_status", 2'd3, 32'h0000_0008);
        wb_rd_chk("midrst_addr", 2'd1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_qspi_flash_prog.md
# wb_qspi_flash_prog

Wishbone-controlled program/erase engine for the configuration SPI flash, complementing the memory-mapped quad-read path. It sequences Write Enable, Sector Erase or Page Program, then Read Status polling until the flash reports not-busy. Payload bytes are staged in an internal word FIFO. It shares the flash pins with the read controller through an external mux; the mux owner guarantees the reader is idle while `busy` is set.

## Interface
- `AW`, 4: Wishbone word-address width. Only `wb_adr_i[1:0]` are decoded.
- `DW`, 32: Wishbone data width. Fixed at 32.
- `FIFO_DEPTH`, 16: payload FIFO depth in 32-bit words. Power of two, max 64.
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_reset_i`  in  1  synchronous, active-low reset.
- `wb_adr_i`  in  AW  word address.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data; zero when not acking.
- `wb_we_i`, `wb_stb_i`, `wb_cyc_i`  in  1  standard Wishbone strobes.
- `wb_sel_i`  in  4  byte selects; ignored (whole-word access).
- `wb_ack_o`  out  1  acknowledge.
- `busy_o`  out  1  high from command accept until the final status poll completes.
- `spi_clk`  out  1  SPI clock (mode 3, idles high).
- `spi_sel`  out  1  chip select, active-low.
- `spi_d_out`  out  4  lane outputs.
- `spi_d_in`  in  4  lane inputs.
- `spi_d_dir`  out  4  lane output enables (1 = drive).

## Operation
Register map (word address):
- 0 CMD, write-only. `[1:0]` op: 1 = sector erase (0x20), 2 = page program, 3 = status read only. Op 0 is a no-op.
- 1 ADDR, read/write. 24-bit flash byte address in `[23:0]`; upper bits read 0.
- 2 DATA, write-only. Pushes one word into the FIFO. Bytes are sent in the order `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`, matching the reader's byte swap.
- 3 STATUS, read-only. `[0]` busy, `[1]` overflow (sticky), `[2]` FIFO full, `[3]` FIFO empty, `[15:8]` last flash status byte, `[22:16]` FIFO level.

Rules:
- CMD write while busy: ignored, still acked.
- CMD write while idle: clears overflow and starts the sequence.
- DATA write when FIFO full: word dropped, overflow set.
- DATA write while busy: allowed unless the FIFO is full.

States:
- IDLE: on a valid CMD, go to WREN (ops 1, 2) or RDSR (op 3).
- WREN: frame 0x06, then GAP.
- GAP: `spi_sel` high for 4 clocks, then the next frame.
- OPC: opcode byte, then ADDR24.
- ADDR24: 24 address bits, MSB first, then DATA (op 2) or GAP→RDSR (op 1).
- DATA: drain the FIFO until empty. An empty FIFO at program start sends zero bytes.
- RDSR: frame 0x05, then read status bytes continuously with `spi_sel` held low. Each complete byte updates STATUS[15:8]. When bit0 = 0, end the frame and go to IDLE.
- Bytes are shifted MSB first.
- `spi_d_dir` is 4'b0001 during command, address and single-lane data; 4'b0000 during status read. Status bits are sampled from `spi_d_in[1]`.
- Frame boundaries: `spi_sel` goes low one clock before the first SCK fall and high one clock after the last SCK rise.

## Timing
- SCK = `wb_clk_i`/2. SCK falls: output changes. SCK rises: input sampled on the same clock edge. One bit takes 2 clocks; one single-lane byte takes 16 clocks.
- Wishbone: `wb_ack_o` is asserted exactly one clock after `stb & cyc & !ack`, for one cycle. It is never stalled.
- `busy_o` rises the clock after a CMD ack and falls in the clock that `spi_sel` returns high after the final poll.
- Reset values: `wb_ack_o` = 0, `wb_dat_o` = 0, `busy_o` = 0, `spi_sel` = 1, `spi_clk` = 1, `spi_d_out` = 0, `spi_d_dir` = 0, ADDR = 0, FIFO empty, overflow = 0, status byte = 0.
- Reset mid-frame: all of the above take effect on the next clock edge, and the FIFO is flushed.
- Simultaneous FIFO push and pop: the level is unchanged. A push on a full FIFO during a pop is accepted.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The level counter is `$clog2(FIFO_DEPTH)+1` bits.
- ADDR is not incremented or page-checked. Page wrap is the flash's behaviour.

## Configuration
- `WB_QSPI_FLASH_PROG_QUAD_EN` defined:
  - Page program uses 0x32 (quad input page program).
  - Opcode and address stay single-lane.
  - Data uses 4 lanes with `spi_d_dir` = 4'b1111, upper nibble first, 2 SCK per byte.
  - The bench sets the flash QE bit beforehand.
- Undefined: page program uses 0x02 with single-lane data, and `spi_d_dir` never exceeds 4'b0001.

## Test plan
- Reset: hold `wb_reset_i` = 0 for 3 clocks mid-transfer → `spi_sel` = 1, `spi_clk` = 1, `busy_o` = 0, STATUS reads 0x0000_0008.
- Erase: ADDR = 0x012000, CMD = 1 → flash model sees frames 06 / 20 01 20 00 / 05. With the model returning 0x03, 0x03, 0x00: `busy_o` falls after the third status byte and STATUS[15:8] = 0x00.
- Program: push 0x44332211 and 0x88776655, ADDR = 0x000100, CMD = 2 → frame 02 00 01 00 11 22 33 44 55 66 77 88. FIFO empty afterwards.
- Overflow: push 17 words with `FIFO_DEPTH` = 16 → STATUS[1] = 1, level = 16. The next CMD write clears overflow.
- Busy guard: CMD = 1 issued while busy → acked in 1 clock, no extra WREN frame.
- Quad (macro defined): one pushed word 0xDDCCBBAA → opcode 0x32, then 8 SCK data cycles. Lanes carry A, A, B, B, C, C, D, D nibbles in order; `spi_d_dir` = 4'b1111.
